rf_wr_arbiter: RTL

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

---
 rtl/rf_pkg.sv | 18 +
 rtl/rr_arb2.sv | 20 ++
 rtl/rf_wr_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter.
package rf_pkg;

    localparam int unsigned DATA_W_DEFAULT = 64;
    localparam int unsigned ADDR_W_DEFAULT = 5;
    // Writes to this index are accepted but never reach the register file.
    localparam int unsigned ZERO_REG       = 31;

    // Bit positions of each requester in the req/gnt vectors.
    localparam int unsigned GNT_ALU = 0;
    localparam int unsigned GNT_MEM = 1;

    typedef enum logic {
        StIdle = 1'b0,
        StLock = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin decision: a lone requester wins, a tie goes to the
// requester that was not granted most recently.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,   // 1: requester 1 was granted most recently
    output logic [1:0] gnt
);

    // Grant decode from request pair and last-grant pointer.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates ALU and load-unit writebacks onto the single register-file write
// port. Load pairs (mem_lock) hold the port for the load unit until the final
// beat is accepted.
module rf_wr_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_lock,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] Rd,
    output logic              enable_registros,
    output logic [DATA_W-1:0] dataWrite,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ZeroRegIdx = ADDR_W'(ZERO_REG);

    arbState_t  stateQ;
    logic       lastMemQ;   // 1: mem was granted most recently
    logic [1:0] req;
    logic [1:0] gnt;

    assign req = {mem_valid, alu_valid};

    rr_arb2 uArb (
        .req  (req),
        .last (lastMemQ),
        .gnt  (gnt)
    );

    // Ready decode: round-robin in IDLE, load unit owns the port in LOCK.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (stateQ == StLock) begin
            mem_ready = mem_valid;
        end else begin
            alu_ready = gnt[GNT_ALU];
            mem_ready = gnt[GNT_MEM];
        end
    end

    assign busy = (stateQ == StLock);

    // State, last-grant pointer and registered write port. Rd/dataWrite only
    // change alongside a real write so they always show the last write issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ           <= StIdle;
            lastMemQ         <= 1'b1;
            enable_registros <= 1'b0;
            Rd               <= '0;
            dataWrite        <= '0;
        end else begin
            enable_registros <= 1'b0;
            if (alu_ready) begin
                lastMemQ <= 1'b0;
                if (alu_rd != ZeroRegIdx) begin
                    enable_registros <= 1'b1;
                    Rd               <= alu_rd;
                    dataWrite        <= alu_data;
                end
            end else if (mem_ready) begin
                lastMemQ <= 1'b1;
                stateQ   <= mem_lock ? StLock : StIdle;
                if (mem_rd != ZeroRegIdx) begin
                    enable_registros <= 1'b1;
                    Rd               <= mem_rd;
                    dataWrite        <= mem_data;
                end
            end
        end
    end

endmodule
